// File: rtl/machine_dispatcher.sv
// Dispatches machine descriptors to NUM_WORKERS solver workers, collects their minima round-robin and reports the sum.
// Optional MACHINE_DISPATCH_UNSOLVABLE_EN: all-ones results are counted as unsolvable instead of summed.
module machine_dispatcher #(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int NUM_WORKERS       = 4,
  parameter int MAX_NUM_PRESSES_W = $clog2(MAX_NUM_BUTTONS+1),
  parameter int SUM_W             = 32
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic                                                    in_last,
  input  logic [$clog2(MAX_NUM_LIGHTS+1)-1:0]                     in_num_lights,
  input  logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]                    in_num_buttons,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]               in_buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                               in_target,
  output logic [NUM_WORKERS-1:0]                                  w_start,
  input  logic [NUM_WORKERS-1:0]                                  w_ready,
  output logic [NUM_WORKERS-1:0]                                  w_accepted,
  output logic [NUM_WORKERS*$clog2(MAX_NUM_LIGHTS+1)-1:0]         w_num_lights,
  output logic [NUM_WORKERS*$clog2(MAX_NUM_BUTTONS+1)-1:0]        w_num_buttons,
  output logic [NUM_WORKERS*MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]   w_buttons,
  output logic [NUM_WORKERS*MAX_NUM_LIGHTS-1:0]                   w_target,
  input  logic [NUM_WORKERS*MAX_NUM_PRESSES_W-1:0]                w_min_presses,
  output logic                                                    total_valid,
  output logic [SUM_W-1:0]                                        total,
  input  logic                                                    total_ack
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
  ,
  output logic [15:0]                                             unsolvable_count
`endif
);
  localparam int NL_W  = $clog2(MAX_NUM_LIGHTS+1);
  localparam int NB_W  = $clog2(MAX_NUM_BUTTONS+1);
  localparam int BT_W  = MAX_NUM_BUTTONS*MAX_NUM_LIGHTS;
  localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_DRAIN} slot_t;
  typedef enum logic [1:0] {P_ACCEPT, P_DRAINING, P_REPORT} phase_t;

  slot_t            slot [NUM_WORKERS];
  logic             drain_cnt [NUM_WORKERS];
  phase_t           phase;
  logic             armed;
  logic [PTR_W-1:0] rr_ptr;

  logic             any_idle, all_idle, coll_hit, handshake;
  logic [PTR_W-1:0] disp_idx, coll_idx, cand;
  logic [MAX_NUM_PRESSES_W-1:0] coll_res;

  function automatic logic is_unsolvable(input logic [MAX_NUM_PRESSES_W-1:0] res);
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
    return &res;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [SUM_W-1:0] add_min(input logic [SUM_W-1:0] acc,
                                               input logic [MAX_NUM_PRESSES_W-1:0] res);
    if (is_unsolvable(res))
      return acc;
    return acc + SUM_W'(res);
  endfunction

  // Lowest-index idle slot for dispatch; round-robin search after rr_ptr for collection
  always_comb begin
    any_idle = 1'b0;
    all_idle = 1'b1;
    disp_idx = '0;
    for (int i = NUM_WORKERS-1; i >= 0; i--) begin
      if (slot[i] == S_IDLE) begin
        any_idle = 1'b1;
        disp_idx = PTR_W'(i);
      end else begin
        all_idle = 1'b0;
      end
    end
    coll_hit = 1'b0;
    coll_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_WORKERS; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_WORKERS);
      if (!coll_hit && slot[cand] == S_RUNNING && w_ready[cand]) begin
        coll_hit = 1'b1;
        coll_idx = cand;
      end
    end
  end

  assign coll_res  = w_min_presses[coll_idx*MAX_NUM_PRESSES_W +: MAX_NUM_PRESSES_W];
  // armed keeps in_ready low while rst is held even though every slot reads IDLE
  assign in_ready  = armed && (phase == P_ACCEPT) && any_idle;
  assign handshake = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORKERS; i++) begin
        slot[i]      <= S_IDLE;
        drain_cnt[i] <= 1'b0;
      end
      phase         <= P_ACCEPT;
      armed         <= 1'b0;
      rr_ptr        <= PTR_W'(NUM_WORKERS-1);
      w_start       <= '0;
      w_accepted    <= '0;
      w_num_lights  <= '0;
      w_num_buttons <= '0;
      w_buttons     <= '0;
      w_target      <= '0;
      total         <= '0;
      total_valid   <= 1'b0;
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
      unsolvable_count <= '0;
`endif
    end else begin
      armed      <= 1'b1;
      w_start    <= '0;
      w_accepted <= '0;
      for (int i = 0; i < NUM_WORKERS; i++) begin
        if (slot[i] == S_DRAIN) begin
          if (drain_cnt[i])
            slot[i] <= S_IDLE;
          drain_cnt[i] <= ~drain_cnt[i];
        end
      end
      if (handshake) begin
        slot[disp_idx]                       <= S_RUNNING;
        w_start[disp_idx]                    <= 1'b1;
        w_num_lights[disp_idx*NL_W +: NL_W]  <= in_num_lights;
        w_num_buttons[disp_idx*NB_W +: NB_W] <= in_num_buttons;
        w_buttons[disp_idx*BT_W +: BT_W]     <= in_buttons;
        w_target[disp_idx*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS] <= in_target;
        if (in_last)
          phase <= P_DRAINING;
      end
      if (coll_hit) begin
        slot[coll_idx]       <= S_DRAIN;
        drain_cnt[coll_idx]  <= 1'b0;
        w_accepted[coll_idx] <= 1'b1;
        rr_ptr               <= coll_idx;
        total                <= add_min(total, coll_res);
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
        if (is_unsolvable(coll_res) && unsolvable_count != 16'hFFFF)
          unsolvable_count <= unsolvable_count + 16'd1;
`endif
      end
      if (phase == P_DRAINING && all_idle) begin
        phase       <= P_REPORT;
        total_valid <= 1'b1;
      end
      if (phase == P_REPORT && total_ack) begin
        phase       <= P_ACCEPT;
        total_valid <= 1'b0;
        total       <= '0;
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
        unsolvable_count <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_machine_dispatcher.sv
// Bench for machine_dispatcher: emulated workers, a timestamp-based reference model and directed machine streams.
module tb_machine_dispatcher;
  localparam int NL  = 10;
  localparam int NBT = 13;
  localparam int NW  = 4;
  localparam int PW  = 4;
  localparam int SW  = 32;
  localparam int NLW = 4;
  localparam int NBW = 4;
  localparam int BTW = NL*NBT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [NLW-1:0] in_num_lights = '0;
  logic [NBW-1:0] in_num_buttons = '0;
  logic [BTW-1:0] in_buttons = '0;
  logic [NL-1:0]  in_target = '0;
  logic [NW-1:0]  w_start, w_accepted;
  logic [NW-1:0]  w_ready = '0;
  logic [NW*NLW-1:0] w_num_lights;
  logic [NW*NBW-1:0] w_num_buttons;
  logic [NW*BTW-1:0] w_buttons;
  logic [NW*NL-1:0]  w_target;
  logic [NW*PW-1:0]  w_min_presses = '0;
  logic total_valid;
  logic [SW-1:0] total;
  logic total_ack = 1'b0;
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
  logic [15:0] unsolvable_count;
`endif

  machine_dispatcher dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_num_lights(in_num_lights), .in_num_buttons(in_num_buttons),
    .in_buttons(in_buttons), .in_target(in_target),
    .w_start(w_start), .w_ready(w_ready), .w_accepted(w_accepted),
    .w_num_lights(w_num_lights), .w_num_buttons(w_num_buttons),
    .w_buttons(w_buttons), .w_target(w_target), .w_min_presses(w_min_presses),
    .total_valid(total_valid), .total(total), .total_ack(total_ack)
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
    , .unsolvable_count(unsolvable_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: slots tracked as running flags plus the cycle number at which a drained slot is free again
  int  m_cyc = 0;
  bit  m_run [NW];
  int  m_free [NW];
  int  m_last = NW-1;
  int  m_phase = 0;            // 0 accepting, 1 draining, 2 reporting
  bit  m_armed = 0;
  logic [NW-1:0] m_start = '0, m_acc = '0;
  logic [SW-1:0] m_total = '0;
  bit  m_tv = 0;
  logic [15:0] m_ucnt = '0;
  logic [NW*NLW-1:0] m_nl = '0;
  logic [NW*NBW-1:0] m_nb = '0;
  logic [NW*BTW-1:0] m_bt = '0;
  logic [NW*NL-1:0]  m_tg = '0;
  int  md_disp, md_coll, md_ph;
  bit  md_allidle, md_unsolv;
  logic [PW-1:0] md_res;

  function automatic bit m_idle(input int i);
    return !m_run[i] && (m_cyc >= m_free[i]);
  endfunction

  function automatic bit m_in_ready();
    bit any = 0;
    for (int i = 0; i < NW; i++) if (m_idle(i)) any = 1;
    return m_armed && (m_phase == 0) && any;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_last = NW-1; m_phase = 0; m_armed = 0;
      m_start = '0; m_acc = '0; m_total = '0; m_tv = 0; m_ucnt = '0;
      m_nl = '0; m_nb = '0; m_bt = '0; m_tg = '0;
      for (int i = 0; i < NW; i++) begin m_run[i] = 0; m_free[i] = 0; end
    end else begin
      md_ph = m_phase;
      md_allidle = 1;
      for (int i = 0; i < NW; i++) if (!m_idle(i)) md_allidle = 0;
      md_disp = -1;
      if (in_valid && m_in_ready())
        for (int i = NW-1; i >= 0; i--) if (m_idle(i)) md_disp = i;
      md_coll = -1;
      for (int k = 1; k <= NW; k++)
        if (md_coll < 0 && m_run[(m_last+k)%NW] && w_ready[(m_last+k)%NW]) md_coll = (m_last+k)%NW;
      m_start = '0;
      m_acc = '0;
      if (md_disp >= 0) begin
        m_start[md_disp] = 1'b1;
        m_run[md_disp] = 1;
        m_nl[md_disp*NLW +: NLW] = in_num_lights;
        m_nb[md_disp*NBW +: NBW] = in_num_buttons;
        m_bt[md_disp*BTW +: BTW] = in_buttons;
        m_tg[md_disp*NL +: NL]   = in_target;
        if (in_last) m_phase = 1;
      end
      if (md_coll >= 0) begin
        m_acc[md_coll] = 1'b1;
        m_run[md_coll] = 0;
        m_free[md_coll] = m_cyc + 3;
        m_last = md_coll;
        md_res = w_min_presses[md_coll*PW +: PW];
        md_unsolv = 0;
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
        md_unsolv = (md_res == 4'hF);
`endif
        if (md_unsolv) begin
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        end else begin
          m_total = m_total + SW'(md_res);
        end
      end
      if (md_ph == 1 && md_allidle) begin m_phase = 2; m_tv = 1; end
      if (md_ph == 2 && total_ack) begin m_phase = 0; m_tv = 0; m_total = '0; m_ucnt = '0; end
      m_armed = 1;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_in_ready());
    chk("w_start", w_start, m_start);
    chk("w_accepted", w_accepted, m_acc);
    chk("total", total, m_total);
    chk("total_valid", total_valid, m_tv);
    chk("w_num_lights", w_num_lights, m_nl);
    chk("w_num_buttons", w_num_buttons, m_nb);
    chk("w_buttons", w_buttons, m_bt);
    chk("w_target", w_target, m_tg);
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
    chk("unsolvable_count", unsolvable_count, m_ucnt);
`endif
  end

  // Worker emulation: latency = num_buttons cycles, result = low 4 bits of the target
  int wcnt [NW];
  int whold [NW];
  bit wbusy [NW];
  bit wdone [NW];
  int hold_extra = 0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NW; i++) begin
      if (rst) begin
        wbusy[i] = 0; w_ready[i] = 1'b0;
      end else if (w_start[i]) begin
        wbusy[i] = 1; wdone[i] = 0; w_ready[i] = 1'b0;
        wcnt[i] = int'(w_num_buttons[i*NBW +: NBW]);
      end else if (wbusy[i]) begin
        if (!w_ready[i]) begin
          if (wcnt[i] == 0) begin
            w_ready[i] = 1'b1;
            w_min_presses[i*PW +: PW] = w_target[i*NL +: PW];
          end else wcnt[i]--;
        end else if (wdone[i]) begin
          if (whold[i] == 0) begin w_ready[i] = 1'b0; wbusy[i] = 0; end
          else whold[i]--;
        end else if (w_accepted[i]) begin
          wdone[i] = 1; whold[i] = hold_extra;
          if (hold_extra == 0) begin w_ready[i] = 1'b0; wbusy[i] = 0; end
        end
      end
    end
  end

  int tb_cyc = 0;
  int start_slot[$];
  int acc_slot[$];
  int acc_cyc[$];
  always @(negedge clk) begin
    tb_cyc++;
    if (!rst)
      for (int i = 0; i < NW; i++) begin
        if (w_start[i]) start_slot.push_back(i);
        if (w_accepted[i]) begin acc_slot.push_back(i); acc_cyc.push_back(tb_cyc); end
      end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    start_slot.delete(); acc_slot.delete(); acc_cyc.delete();
    @(posedge clk); #1;
  endtask

  task automatic send(input int nb, input int res, input bit last);
    logic [159:0] pat;
    int waited = 0;
    pat = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_last = last;
    in_num_buttons = NBW'(nb);
    in_num_lights  = NLW'((nb % 10) + 1);
    in_buttons     = pat[BTW-1:0];
    in_target      = NL'((nb << 4) | res);
    forever begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; break; end
      if (++waited > 200) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: got no in_ready expected handshake");
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_report(input string nm);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (total_valid) break;
      if (++waited > 300) begin
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: got total_valid=0 expected 1", nm);
        break;
      end
    end
  endtask

  task automatic ack();
    @(posedge clk); #1 total_ack = 1'b1;
    @(posedge clk); #1 total_ack = 1'b0;
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_total_valid", total_valid, 0);
    chk("reset_w_start", w_start, 0);
    do_reset();

    // Five machines on four workers; the fifth lands on slot 1, the first one freed
    send(3, 2, 0); send(1, 3, 0); send(4, 2, 0); send(5, 1, 0); send(1, 1, 1);
    ack();
    wait_report("t1");
    chk("t1_total", total, 9);
    chk("t1_fifth_slot", q_at(start_slot, 4), 1);
    ack();

    // Ready held past acceptance yields one collection only
    do_reset();
    hold_extra = 2;
    send(2, 5, 1);
    wait_report("t2");
    chk("t2_total", total, 5);
    chk("t2_accept_count", acc_slot.size(), 1);
    hold_extra = 0;
    ack();

    // Full occupancy, then simultaneous ready on slots 1 and 3
    do_reset();
    send(12, 1, 0); send(8, 2, 0); send(12, 3, 0); send(6, 4, 0);
    @(negedge clk);
    chk("t3_full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    send(1, 0, 1);
    wait_report("t3");
    chk("t3_first_acc", q_at(acc_slot, 0), 1);
    chk("t3_second_acc", q_at(acc_slot, 1), 3);
    chk("t3_acc_gap", q_at(acc_cyc, 1) - q_at(acc_cyc, 0), 1);
    chk("t3_fifth_slot", q_at(start_slot, 4), 1);
    chk("t3_total", total, 10);

    // Report held without acknowledge
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_total", total, 10);
      chk("t4_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 total_ack = 1'b1;
    @(posedge clk); #1 total_ack = 1'b0;
    @(negedge clk);
    chk("t4_ack_total", total, 0);
    chk("t4_ack_in_ready", in_ready, 1);
    chk("t4_ack_valid", total_valid, 0);

    // Reset while draining with two machines in flight
    do_reset();
    send(13, 1, 0); send(13, 2, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_w_start", w_start, 0);
    chk("t5_rst_w_target", w_target, 0);
    chk("t5_rst_total_valid", total_valid, 0);
    @(posedge clk); #2 rst = 1'b0;
    start_slot.delete(); acc_slot.delete(); acc_cyc.delete();
    @(posedge clk); #1;
    send(2, 6, 1);
    wait_report("t5");
    chk("t5_total", total, 6);
    chk("t5_slot", q_at(start_slot, 0), 0);
    ack();

    // All-ones result
    do_reset();
    send(2, 3, 0); send(3, 15, 1);
    wait_report("t6");
`ifdef MACHINE_DISPATCH_UNSOLVABLE_EN
    chk("t6_total", total, 3);
    chk("t6_unsolvable", unsolvable_count, 1);
    ack();
    @(negedge clk);
    chk("t6_unsolvable_cleared", unsolvable_count, 0);
`else
    chk("t6_total", total, 18);
    ack();
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/machine_dispatcher.md
Name: machine_dispatcher

Overview:
- Schedules a stream of day-10 machine descriptions onto NUM_WORKERS parallel machine-configuration workers.
- Each worker accepts one machine description, solves it, and reports the minimum number of button presses for that machine.
- This block latches each incoming machine, starts an idle worker, collects results through the workers' ready/accepted handshake, and accumulates the per-machine minima into a puzzle total.
- It sits between the input parser stream and the answer output.

Parameters:
- MAX_NUM_LIGHTS, 10: max lights per machine.
- MAX_NUM_BUTTONS, 13: max buttons per machine.
- NUM_WORKERS, 4: number of worker instances managed; must be ≥1.
- MAX_NUM_PRESSES_W, $clog2(MAX_NUM_BUTTONS+1): width of a worker result.
- SUM_W, 32: width of the total accumulator.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: machine descriptor valid.
- in_ready, output, 1: descriptor accepted when in_valid && in_ready.
- in_last, input, 1: descriptor is the final machine of the puzzle.
- in_num_lights, input, $clog2(MAX_NUM_LIGHTS+1): lights count.
- in_num_buttons, input, $clog2(MAX_NUM_BUTTONS+1): buttons count.
- in_buttons, input, MAX_NUM_BUTTONS*MAX_NUM_LIGHTS: button b occupies bits [b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS].
- in_target, input, MAX_NUM_LIGHTS: target light arrangement.
- w_start, output, NUM_WORKERS: per-worker start pulse.
- w_ready, input, NUM_WORKERS: per-worker result ready (level, held until accepted).
- w_accepted, output, NUM_WORKERS: per-worker result-accepted pulse.
- w_num_lights / w_num_buttons / w_buttons / w_target, output, NUM_WORKERS × the matching in_* width: per-worker registered descriptor.
- w_min_presses, input, NUM_WORKERS*MAX_NUM_PRESSES_W: per-worker result.
- total_valid, output, 1: puzzle total available.
- total, output, SUM_W: sum of collected minima.
- total_ack, input, 1: consumer took the total.

Behaviour:
- Reset (async, rst=1): all worker slots IDLE; all w_start and w_accepted = 0; descriptor registers = 0; total = 0; total_valid = 0; in_ready = 0; phase = ACCEPT.
- Deassertion of rst is synchronised by the usual reset bridge upstream.
- Reset mid-operation abandons all in-flight machines; workers are reset by the same rst.
- Per-worker slot FSM:
  - IDLE → RUNNING on dispatch.
  - RUNNING → DRAIN on collect.
  - DRAIN → IDLE after exactly 2 cycles. The worker's ready is registered and can stay high one cycle after accepted, so w_ready is ignored outside RUNNING.
- Dispatch:
  - in_ready = (phase == ACCEPT) && (any slot IDLE).
  - On handshake, the lowest-index IDLE slot i loads its descriptor registers.
  - w_start[i] pulses for exactly 1 cycle, in the cycle after the handshake, with the descriptor already stable.
  - Slot i enters RUNNING in that same cycle.
  - At most one dispatch per cycle. Descriptor registers hold until the next dispatch to that slot.
- Collect:
  - Among slots with RUNNING && w_ready, a round-robin pointer (starting after the last collected slot) selects one slot per cycle.
  - w_accepted[j] is a registered 1-cycle pulse.
  - total += zero-extended w_min_presses[j], sampled in the selection cycle. Addition wraps modulo 2^SUM_W.
  - Dispatch and collect in the same cycle on different slots are both performed.
- Phases:
  - ACCEPT → DRAINING on a handshake with in_last=1. in_ready = 0 while DRAINING.
  - DRAINING → REPORT when all slots are IDLE. total_valid=1 and total is held.
  - REPORT → ACCEPT on total_ack, with total cleared to 0 the same edge. total_ack outside REPORT is ignored.
- Latency: handshake → w_start is 1 cycle. Selection → w_accepted is 1 cycle. Last collect → total_valid is 3 cycles (2 DRAIN + 1).

Optional Feature:
- Macro: MACHINE_DISPATCH_UNSOLVABLE_EN.
- When defined:
  - A w_min_presses of all-ones marks an unsolvable machine and is not added to total.
  - An extra output unsolvable_count (16 bits, reset 0, cleared with total on total_ack, saturating) increments per such result.
- When undefined: all-ones is added like any other value, and the port does not exist.

Test Plan:
- NUM_WORKERS=2. Feed 3 machines whose workers return 2, 3, 2, last on the third → total_valid with total=7. The third machine dispatches to the first slot freed, only after that slot's 2-cycle DRAIN.
- One machine with in_last; w_ready held 2 extra cycles after w_accepted → exactly one accepted pulse; total equals that single result.
- All 4 workers RUNNING → in_ready=0. Then w_ready on slots 1 and 3 in the same cycle → accepted on slot 1 then slot 3 on consecutive cycles (round-robin); in_ready rises once a DRAIN completes.
- Hold total_ack=0 for 10 cycles in REPORT → total stable, in_ready=0. Pulse total_ack → total=0 and in_ready=1 next cycle.
- Assert rst mid-DRAINING with 2 slots RUNNING → all outputs return to reset values immediately; a fresh machine is accepted after rst drops.
- With MACHINE_DISPATCH_UNSOLVABLE_EN: results 3 and all-ones → total=3, unsolvable_count=1.
